simd_add_arbiter: RTL and testbench



---
 rtl/simd_add_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_simd_add_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_add_arbiter.sv
// Round-robin arbiter feeding a shared 4-lane SIMD adder; tags each result with its
// requester through a latency-matched tag pipeline and supports enable/drain quiescing.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | not granting, nothing in flight
// RUN    | granting one request per ce cycle, round-robin from ptr
// DRAIN  | not granting, waiting for in-flight results to return
module simd_add_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 10,
  parameter int LANES = 4,
  parameter int LAT   = 2
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      ap_ce,
  input  logic                      en,
  input  logic [NREQ-1:0]           req_vld,
  output logic [NREQ-1:0]           req_rdy,
  input  logic [NREQ*LANES*W-1:0]   req_a,
  input  logic [NREQ*LANES*W-1:0]   req_b,
  output logic                      add_start,
  output logic [LANES*W-1:0]        add_a,
  output logic [LANES*W-1:0]        add_b,
  input  logic                      add_vld,
  input  logic [LANES*W-1:0]        add_z,
  output logic                      rsp_vld,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [LANES*W-1:0]        rsp_z,
  output logic                      idle,
  output logic                      err
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int VW    = LANES * W;
  localparam int CNT_W = $clog2(LAT + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             add_start_q, add_start_d;
  logic [VW-1:0]    add_a_q, add_a_d, add_b_q, add_b_d;
  logic [ID_W-1:0]  add_id_q, add_id_d;
  logic [LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]  tag_id_q [LAT];
  logic [ID_W-1:0]  tag_id_d [LAT];
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;

  logic [ID_W-1:0]  win_id, cand;
  logic             found, grant_en, transfer, inc, dec;
  logic [VW-1:0]    op_a [NREQ];
  logic [VW-1:0]    op_b [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_a[i] = req_a[i*VW +: VW];
    assign op_b[i] = req_b[i*VW +: VW];
  end

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    win_id = ptr_q;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NREQ);
      if (!found && req_vld[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  // en gates the grant directly so req_rdy drops in the same cycle en falls.
  assign grant_en = (state_q == S_RUN) && en && ap_ce && !ap_rst;
  assign transfer = grant_en && found;
  assign req_rdy  = transfer ? (NREQ'(1) << win_id) : '0;

  always_comb begin
    add_start_d = add_start_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_id_d    = add_id_q;
    ptr_d       = ptr_q;
    if (ap_ce) begin
      add_start_d = transfer;
      if (transfer) begin
        add_a_d  = op_a[win_id];
        add_b_d  = op_b[win_id];
        add_id_d = win_id;
        ptr_d    = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;
      end
    end
  end

  always_comb begin
    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    if (ap_ce) begin
      tag_vld_d[0] = add_start_q;
      tag_id_d[0]  = add_id_q;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_d[k] = tag_vld_q[k-1];
        tag_id_d[k]  = tag_id_q[k-1];
      end
    end
  end

  // A stray adder valid with nothing outstanding is flagged by err, not counted.
  assign inc = transfer;
  assign dec = add_vld && ap_ce && (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    if (inc && !dec)      inflight_d = inflight_q + CNT_W'(1);
    else if (dec && !inc) inflight_d = inflight_q - CNT_W'(1);
  end

  // Leaving DRAIN looks at the post-edge count so idle rises right after the last result.
  always_comb begin
    state_d = state_q;
    if (ap_ce) begin
      case (state_q)
        S_IDLE:  if (en) state_d = S_RUN;
        S_RUN:   if (!en) state_d = S_DRAIN;
        S_DRAIN: begin
          if (en)                                         state_d = S_RUN;
          else if (inflight_d == '0 && !add_start_q)      state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign err_d = err_q || (ap_ce && (add_vld != tag_vld_q[LAT-1]));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_id_q    <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '{default: '0};
      inflight_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_start_q <= add_start_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_id_q    <= add_id_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  // The counter is sized for the deepest possible pipeline; hitting the top is a bug.
  always @(posedge ap_clk) begin
    if (!ap_rst && inc && !dec) assert (inflight_q != {CNT_W{1'b1}});
  end

  assign add_start = add_start_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_vld   = add_vld && ap_ce;
  assign rsp_id    = tag_id_q[LAT-1];
  assign rsp_z     = add_z;
  assign idle      = (state_q == S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_simd_add_arbiter.sv
// Directed bench for simd_add_arbiter: grant table, response scoreboard driven by a
// 2-stage adder model, and hand-written stall, drain, reset and mismatch sequences.
module tb_simd_add_arbiter;
  localparam int NREQ = 4, W = 10, LANES = 4, LAT = 2;
  localparam int VW = LANES * W;

  logic                  ap_clk, ap_rst, ap_ce, en;
  logic [NREQ-1:0]       req_vld, req_rdy;
  logic [NREQ*VW-1:0]    req_a, req_b;
  logic                  add_start, add_vld, rsp_vld, idle, err;
  logic [VW-1:0]         add_a, add_b, add_z, rsp_z;
  logic [1:0]            rsp_id;
  logic                  force_vld;

  simd_add_arbiter #(.NREQ(NREQ), .W(W), .LANES(LANES), .LAT(LAT)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .en(en),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_vld(add_vld), .add_z(add_z),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .idle(idle), .err(err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  function automatic logic [VW-1:0] vsum(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = '0;
    for (int j = 0; j < LANES; j++) r[j*W +: W] = a[j*W +: W] + b[j*W +: W];
    return r;
  endfunction

  // Adder model: start sampled on one ce edge, valid visible after the next.
  logic          s1_v, s2_v;
  logic [VW-1:0] s1_z, s2_z;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_z <= '0; s2_z <= '0;
    end else if (ap_ce) begin
      s1_v <= add_start; s1_z <= vsum(add_a, add_b);
      s2_v <= s1_v;      s2_z <= s1_z;
    end
  end
  assign add_vld = s2_v | force_vld;
  assign add_z   = s2_z;

  typedef struct { logic [3:0] vld; logic [3:0] rdy; } vec_t;
  typedef struct { int due; int id; logic [VW-1:0] z; } exp_t;

  exp_t          q[$];
  vec_t          tbl[15];
  int            n_cmp = 0, n_bad = 0;
  int            cecnt = 0, cyc_n = 0, last_rsp = 0, rsp_cnt = 0;
  bit            mon_en = 1'b1;
  logic [1:0]    last_id;
  logic [VW-1:0] last_z;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc_n);
    end
  endtask

  task automatic sample();
    exp_t e;
    @(negedge ap_clk);
    cyc_n++;
    if (!ap_rst) begin
      if (mon_en) begin
        if (rsp_vld) begin
          rsp_cnt++;
          last_id = rsp_id;
          last_z  = rsp_z;
          if (q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            e = q.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_z", 64'(rsp_z), 64'(e.z));
            chk("rsp_latency", 64'(cecnt), 64'(e.due));
          end
        end else if (ap_ce && q.size() > 0 && q[0].due <= cecnt) begin
          chk("rsp_missing", 64'(rsp_vld), 1);
          void'(q.pop_front());
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          e.due = cecnt + 3;
          e.id  = i;
          e.z   = vsum(req_a[i*VW +: VW], req_b[i*VW +: VW]);
          q.push_back(e);
        end
      end
      chk("rdy_onehot", 64'($countones(req_rdy) <= 1), 1);
    end
    if (rsp_vld) last_rsp = cyc_n;
  endtask

  task automatic advance();
    logic ce_now;
    ce_now = ap_ce;
    @(posedge ap_clk);
    if (ce_now) cecnt++;
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic check_quiet();
    chk("quiet_rdy", 64'(req_rdy), 0);
    chk("quiet_idle", 64'(idle), 1);
    chk("quiet_start", 64'(add_start), 0);
    chk("quiet_rsp", 64'(rsp_vld), 0);
    chk("quiet_err", 64'(err), 0);
  endtask

  task automatic do_reset();
    ap_rst = 1'b1; en = 1'b0; req_vld = '0; ap_ce = 1'b1; force_vld = 1'b0;
    tick();
    q.delete();
    ap_rst = 1'b0;
  endtask

  task automatic set_all_ops(input int r);
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < LANES; j++) begin
        req_a[i*VW + j*W +: W] = W'(i*50 + r*3 + j);
        req_b[i*VW + j*W +: W] = W'(1000 + j*7 + r);
      end
  endtask

  initial begin
    int r0, idle_cyc;
    for (int r = 0; r < 8; r++) tbl[r] = '{4'b1111, 4'(1 << (r % 4))};
    tbl[8]  = '{4'b1010, 4'b0010};
    tbl[9]  = '{4'b1010, 4'b1000};
    tbl[10] = '{4'b0001, 4'b0001};
    tbl[11] = '{4'b0001, 4'b0001};
    tbl[12] = '{4'b0000, 4'b0000};
    tbl[13] = '{4'b1100, 4'b0100};
    tbl[14] = '{4'b0101, 4'b0001};

    ap_rst = 1'b1; ap_ce = 1'b1; en = 1'b0; req_vld = 4'b1111;
    req_a = '0; req_b = '0; force_vld = 1'b0; last_id = '0; last_z = '0;
    @(posedge ap_clk); #1;

    // Reset held with all requests valid, then released with en low.
    repeat (3) begin sample(); check_quiet(); advance(); end
    ap_rst = 1'b0;
    repeat (2) begin sample(); check_quiet(); advance(); end

    // Single requester stream with lane wrap.
    req_vld = '0;
    req_a[2*VW +: VW] = {10'd1023, 10'd3, 10'd2, 10'd1};
    req_b[2*VW +: VW] = {10'd1, 10'd1, 10'd1, 10'd1};
    en = 1'b1;
    sample(); chk("run_entry_rdy", 64'(req_rdy), 0); advance();
    r0 = rsp_cnt;
    req_vld = 4'b0100;
    repeat (4) begin sample(); chk("single_rdy", 64'(req_rdy), 4'b0100); advance(); end
    req_vld = '0;
    repeat (6) tick();
    chk("single_count", 64'(rsp_cnt - r0), 4);
    chk("single_last_id", 64'(last_id), 2);
    chk("single_last_z", 64'(last_z), 64'({10'd0, 10'd4, 10'd3, 10'd2}));

    // Round-robin contention table.
    do_reset();
    en = 1'b1;
    tick();
    r0 = rsp_cnt;
    for (int r = 0; r < 15; r++) begin
      req_vld = tbl[r].vld;
      set_all_ops(r);
      sample(); chk("tbl_rdy", 64'(req_rdy), 64'(tbl[r].rdy)); advance();
    end
    req_vld = '0;
    repeat (6) tick();
    chk("tbl_count", 64'(rsp_cnt - r0), 14);
    chk("tbl_queue_empty", 64'(q.size()), 0);

    // Clock-enable stall right after two accepts.
    do_reset();
    en = 1'b1;
    tick();
    set_all_ops(20);
    req_vld = 4'b0011;
    sample(); chk("stall_rdy0", 64'(req_rdy), 4'b0001); advance();
    sample(); chk("stall_rdy1", 64'(req_rdy), 4'b0010); advance();
    ap_ce = 1'b0; req_vld = 4'b1111;
    repeat (5) begin
      sample(); chk("stall_rdy", 64'(req_rdy), 0); chk("stall_rsp", 64'(rsp_vld), 0); advance();
    end
    ap_ce = 1'b1; req_vld = '0;
    sample(); chk("stall_ce1_rsp", 64'(rsp_vld), 0); advance();
    sample(); chk("stall_ce2_rsp", 64'(rsp_vld), 1); chk("stall_ce2_id", 64'(rsp_id), 0); advance();
    sample(); chk("stall_ce3_rsp", 64'(rsp_vld), 1); chk("stall_ce3_id", 64'(rsp_id), 1); advance();
    repeat (3) tick();

    // Drop en during a full stream.
    do_reset();
    en = 1'b1;
    tick();
    r0 = rsp_cnt;
    req_vld = 4'b1111;
    for (int r = 0; r < 6; r++) begin set_all_ops(30 + r); tick(); end
    en = 1'b0;
    sample(); chk("drain_rdy", 64'(req_rdy), 0); advance();
    idle_cyc = -1;
    for (int k = 0; k < 12 && idle_cyc < 0; k++) begin
      sample();
      if (idle) idle_cyc = cyc_n;
      advance();
    end
    req_vld = '0;
    chk("drain_idle_seen", 64'(idle_cyc >= 0), 1);
    chk("drain_idle_time", 64'(idle_cyc), 64'(last_rsp + 1));
    chk("drain_count", 64'(rsp_cnt - r0), 6);
    chk("drain_queue_empty", 64'(q.size()), 0);
    chk("drain_err", 64'(err), 0);

    // Reset while operations are in flight; reset wins over en.
    do_reset();
    en = 1'b1;
    tick();
    req_vld = 4'b1111;
    set_all_ops(40);
    repeat (3) tick();
    ap_rst = 1'b1;
    sample(); chk("rst_mid_rdy", 64'(req_rdy), 0); advance();
    q.delete();
    ap_rst = 1'b0; en = 1'b0; req_vld = '0;
    repeat (6) begin
      sample(); chk("rst_mid_rsp", 64'(rsp_vld), 0); chk("rst_mid_idle", 64'(idle), 1); advance();
    end

    // Stray adder valid sets sticky err.
    do_reset();
    mon_en = 1'b0;
    sample(); chk("err_before", 64'(err), 0); advance();
    force_vld = 1'b1;
    tick();
    force_vld = 1'b0;
    repeat (3) begin sample(); chk("err_sticky", 64'(err), 1); advance(); end
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    mon_en = 1'b1;
    sample(); chk("err_cleared", 64'(err), 0); advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
